// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer family: state encoding and counter width helper.
package piso_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_t;

  // Bit-position counter width; at least one bit so narrow words stay legal.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit-position counter with clear/enable and a terminal-count flag.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Clear has priority so a load coincident with the final beat restarts at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready on both sides, per-word bit order,
// last/done flags and zero-bubble back-to-back words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_dir;
  logic             r_done;
  logic             w_load;
  logic             w_beat;
  logic             w_tc;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_load),
    .i_en  (w_beat),
    .o_tc  (w_tc)
  );

  assign ser_valid = (r_state == S_SHIFT);
  assign w_beat    = ser_valid & ser_ready;
  // Ready also opens on the final accepted beat so the next word follows with no gap.
  assign in_ready  = !rst & ((r_state == S_IDLE) | (w_beat & w_tc));
  assign w_load    = in_valid & in_ready;

  // FSM, shift register, direction flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= {WIDTH{FILL}};
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_beat & w_tc;
      if (w_load) begin
        r_shreg <= in_data;
        r_dir   <= msb_first;
        r_state <= S_SHIFT;
      end else if (w_beat) begin
        r_shreg <= r_dir ? {r_shreg[WIDTH-2:0], FILL} : {FILL, r_shreg[WIDTH-1:1]};
        if (w_tc) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign ser_data = r_dir ? r_shreg[WIDTH-1] : r_shreg[0];
  assign ser_last = ser_valid & w_tc;
  assign busy     = ser_valid;
  assign done     = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words are expanded into expected bit
// streams, and a monitor checks every serial beat, flag and ready against them.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         msb_first;
  logic         ser_data, ser_valid, ser_ready, ser_last, busy, done;

  logic [W-1:0] f_in_data;
  logic         f_in_valid, f_in_ready, f_ser_data, f_ser_valid, f_ser_last, f_busy, f_done;

  piso_serializer #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .msb_first(msb_first), .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_last(ser_last), .busy(busy), .done(done)
  );

  piso_serializer #(.WIDTH(W), .FILL(1'b1)) dut_fill (
    .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .msb_first(1'b1), .ser_data(f_ser_data), .ser_valid(f_ser_valid), .ser_ready(ser_ready),
    .ser_last(f_ser_last), .busy(f_busy), .done(f_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Each entry: {bit, last}; only the word currently being shifted is ever outstanding.
  logic [1:0] exp_q[$];
  logic       exp_done = 1'b0;
  logic       rst_prev = 1'b0;
  logic       loading  = 1'b0;
  logic       rnd_mode = 1'b0;
  int         stall_req = 0;
  int         words_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle, when the inputs for the next rising edge are settled.
  always @(negedge clk) begin
    logic [1:0] head;
    logic       nxt_done;
    nxt_done = 1'b0;
    if (rst) begin
      chk("in_ready_in_rst", in_ready, 0);
      if (rst_prev) begin
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_done", done, 0);
        chk("rst_fill_ser_data", f_ser_data, 1);
      end
      exp_q.delete();
    end else begin
      chk("ser_valid", ser_valid, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("done", done, exp_done);
      chk("in_ready", in_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && ser_ready));
      chk("fill_idle_data", f_ser_data, 1);
      if (exp_q.size() == 0) begin
        chk("idle_ser_data", ser_data, 0);
        chk("idle_ser_last", ser_last, 0);
      end else begin
        head = exp_q[0];
        chk("ser_data", ser_data, head[1]);
        chk("ser_last", ser_last, head[0]);
        if (ser_ready) begin
          void'(exp_q.pop_front());
          nxt_done = head[0];
          if (head[0]) words_done++;
        end
      end
    end
    exp_done = nxt_done;
    rst_prev = rst;
  end

  // Consumer ready and mid-word msb_first churn.
  initial begin
    ser_ready = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      if (stall_req > 0) begin
        ser_ready = 1'b0;
        stall_req--;
      end else begin
        ser_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (!loading) msb_first = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic dir);
    bit ok;
    ok = 0;
    @(posedge clk);
    #2;
    in_data   = d;
    msb_first = dir;
    in_valid  = 1'b1;
    loading   = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (in_ready) begin
        #1;
        for (int i = 0; i < W; i++) begin
          exp_q.push_back({dir ? d[W-1-i] : d[i], 1'(i == W - 1)});
        end
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_mis++;
      $display("FAIL load_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic release_word();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    loading  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int wd0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    msb_first  = 1'b0;
    f_in_valid = 1'b0;
    f_in_data  = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle(2);

    send_word(8'hC1, 1'b1); release_word(); idle(10);
    send_word(8'hC1, 1'b0); release_word(); idle(10);

    send_word(8'hA5, 1'b1); release_word();
    idle(2);
    stall_req = 3;
    idle(14);

    wd0 = words_done;
    send_word(8'hF0, 1'b1); send_word(8'h0F, 1'b1); release_word(); idle(20);
    chk("b2b_word_count", words_done - wd0, 2);

    send_word(8'hFF, 1'b1); release_word();
    idle(2);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    idle(3);
    send_word(8'h80, 1'b1); release_word(); idle(10);

    rnd_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_word(W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) begin
        release_word();
        idle($urandom_range(0, 4));
      end
    end
    release_word();
    for (int g = 0; g < 400 && exp_q.size() != 0; g++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: got %0d bits left expected 0", exp_q.size());
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
